// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant and a bounded
// per-owner hold window; the owner keeps the grant while requesting, up to MAX_HOLD cycles.
module rr_arbiter_hold #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 4,
   localparam int unsigned IDW     = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic [15:0]    hold_cnt
);

   localparam int unsigned CNTW = 16;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(MAX_HOLD);
   localparam logic [CNTW-1:0] CNT_SAT  = {CNTW{1'b1}};

   logic [0:0]      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic [CNTW-1:0] hold_q, hold_d;
   logic [IDW-1:0]  last_q, last_d;

   logic [IDW-1:0]  pick_last;
   logic [IDW-1:0]  pick_own;
   logic            own_req;
   logic [N-1:0]    others;

   // First requester strictly after x, wrapping around and reaching x itself last.
   function automatic logic [IDW-1:0] pick(input logic [IDW-1:0] x, input logic [N-1:0] r);
      logic [IDW-1:0] sel;
      logic           found;
      logic [31:0]    idx;
      sel   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (32'(x) + k) % N;
         if (!found && r[idx[IDW-1:0]]) begin
            sel   = idx[IDW-1:0];
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      hold_d      = hold_q;
      last_d      = last_q;

      pick_last = pick(last_q, req);
      pick_own  = pick(gnt_id_q, req);
      own_req   = req[gnt_id_q];
      others    = req & ~gnt_q;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = GRANT;
               gnt_d       = N'(1) << pick_last;
               gnt_valid_d = 1'b1;
               gnt_id_d    = pick_last;
               hold_d      = CNTW'(1);
            end
         end
         GRANT: begin
            if (!own_req) begin
               // Release: hand over in the same edge, or go idle.
               last_d = gnt_id_q;
               if (|req) begin
                  gnt_d    = N'(1) << pick_own;
                  gnt_id_d = pick_own;
                  hold_d   = CNTW'(1);
               end else begin
                  state_d     = IDLE;
                  gnt_d       = '0;
                  gnt_valid_d = 1'b0;
                  gnt_id_d    = '0;
                  hold_d      = '0;
               end
            end else if (MAX_HOLD == 0 || hold_q < HOLD_MAX) begin
               if (hold_q != CNT_SAT) begin
                  hold_d = hold_q + CNTW'(1);
               end
            end else begin
               // Hold window exhausted: rotate if anyone else waits, else restart window.
               last_d = gnt_id_q;
               hold_d = CNTW'(1);
               if (|others) begin
                  gnt_d    = N'(1) << pick_own;
                  gnt_id_d = pick_own;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            hold_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         hold_q      <= '0;
         last_q      <= IDW'(N - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         hold_q      <= hold_d;
         last_q      <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign hold_cnt  = hold_q;

endmodule
